// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding for the debounce/edge-detect stage
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } debounce_state_t;

  function automatic debounce_state_t stable_state(input logic lvl);
    return lvl ? STABLE_HI : STABLE_LO;
  endfunction

endpackage

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - debounced level with registered rise/fall pulses
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_cycles
      $error("debounce_edge: DEBOUNCE_CYCLES must be in 2..2^20");
    end
  endgenerate

  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Pulses default low every clk so they last one cycle even when tick stays low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      case (state_q)
        STABLE_LO: begin
          if (din) begin
            state_d = CHK_HI;
            cnt_d   = CNT_W'(1);
          end
        end
        CHK_HI: begin
          if (!din) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!din) begin
            state_d = CHK_LO;
            cnt_d   = CNT_W'(1);
          end
        end
        CHK_LO: begin
          if (din) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = stable_state(level_q);
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= stable_state(INIT_LEVEL);
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule
